// File: rtl/hsfir_seq.sv
// Time-multiplexed signed FIR: one shared multiplier walks NTAPS taps per accepted
// sample, then rounds, saturates and emits a single-cycle output pulse.
module hsfir_seq #(
    parameter int IW    = 8,
    parameter int OW    = 8,
    parameter int CW    = 8,
    parameter int NTAPS = 8,
    parameter int SHIFT = 6
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_ce,
    input  logic [IW-1:0]            i_data,
    output logic                     o_ready,
    input  logic                     i_cwr,
    input  logic [$clog2(NTAPS)-1:0] i_caddr,
    input  logic [CW-1:0]            i_cdata,
    output logic                     o_ce,
    output logic [OW-1:0]            o_data,
    output logic                     o_sat
);
    localparam int TW = $clog2(NTAPS);
    localparam int AW = IW + CW + TW;
    localparam logic signed [AW:0] YMAX = (AW+1)'((1 <<< (OW-1)) - 1);
    localparam logic signed [AW:0] YMIN = (AW+1)'(-(1 <<< (OW-1)));

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state, state_nx;
    logic [TW-1:0]            idx;
    logic signed [AW-1:0]     acc;
    logic signed [IW-1:0]     x [NTAPS];
    logic signed [CW-1:0]     h [NTAPS];
    logic signed [IW+CW-1:0]  prod;
    logic signed [AW:0]       scaled;
    logic                     accept, last, sat_hi, sat_lo;
    logic [OW-1:0]            y;

    assign o_ready = (state == IDLE);
    assign accept  = o_ready && i_ce;
    assign last    = (idx == TW'(NTAPS-1));
    assign prod    = h[idx] * x[idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_ce) state_nx = MAC;
            MAC:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Writes only land in IDLE, so a computation always sees one coefficient set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NTAPS; k++)
                h[k] <= (k == 0) ? CW'(1 <<< SHIFT) : '0;
        end else if (o_ready && i_cwr) begin
            h[i_caddr] <= i_cdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            x[0] <= i_data;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            acc <= '0;
            idx <= '0;
        end else if (state == MAC) begin
            acc <= acc + AW'(prod);
            idx <= idx + TW'(1);
        end
    end

    generate
        if (SHIFT > 0) begin : g_round
            logic signed [AW:0] rnd;
            assign rnd    = (AW+1)'(acc) + (AW+1)'(1 <<< (SHIFT-1));
            assign scaled = rnd >>> SHIFT;
        end else begin : g_noround
            assign scaled = (AW+1)'(acc);
        end
    endgenerate

    assign sat_hi = (scaled > YMAX);
    assign sat_lo = (scaled < YMIN);
    assign y      = sat_hi ? YMAX[OW-1:0] : (sat_lo ? YMIN[OW-1:0] : scaled[OW-1:0]);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ce   <= 1'b0;
            o_data <= '0;
            o_sat  <= 1'b0;
        end else begin
            o_ce  <= (state == DONE);
            o_sat <= (state == DONE) && (sat_hi || sat_lo);
            if (state == DONE) o_data <= y;
        end
    end
endmodule
